// File: rtl/memory_unit.sv
// memory_unit: byte-addressed big-endian RAM behind a MOV/MOC handshake with programmable latency
module memory_unit #(
  parameter int    ADDR_W    = 8,
  parameter int    LATENCY   = 2,
  parameter string INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              MOV,
  input  logic              R_W,
  input  logic [1:0]        size,
  input  logic              SE,
  input  logic [ADDR_W-1:0] address,
  input  logic [31:0]       data_in,
  output logic [31:0]       data_out,
  output logic              MOC,
  output logic              err
);
  typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;
  state_t            state_q;
  logic [3:0]        cnt_q;
  logic              rw_q, se_q, err_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q, a1, a2, a3;
  logic [31:0]       wdata_q, data_out_q, rdata;
  logic [7:0]        mem [2**ADDR_W];
  logic [7:0]        b0, b1, b2, b3;
  logic              fault, fire;
  assign a1 = addr_q + ADDR_W'(1);
  assign a2 = addr_q + ADDR_W'(2);
  assign a3 = addr_q + ADDR_W'(3);
  assign fire = state_q == ACCESS && cnt_q == 4'd0;
  // misaligned halfword/word or the reserved size code faults the whole access
  always_comb begin
    fault = size_q == 2'b11 || (size_q == 2'b01 && addr_q[0]) || (size_q == 2'b10 && addr_q[1:0] != 2'b00);
    b0 = mem[addr_q];
    b1 = mem[a1];
    b2 = mem[a2];
    b3 = mem[a3];
    rdata = size_q == 2'b00 ? {{24{se_q & b0[7]}}, b0} :
            size_q == 2'b01 ? {{16{se_q & b0[7]}}, b0, b1} :
            size_q == 2'b10 ? {b0, b1, b2, b3} : 32'd0;
  end
  // array is never cleared; a write commits only on the final ACCESS edge without reset or fault
  always_ff @(posedge clk) begin
    if (!clr && fire && !rw_q && !fault) begin
      mem[addr_q] <= size_q == 2'b00 ? wdata_q[7:0] : size_q == 2'b01 ? wdata_q[15:8] : wdata_q[31:24];
      if (size_q != 2'b00) mem[a1] <= size_q == 2'b01 ? wdata_q[7:0] : wdata_q[23:16];
      if (size_q == 2'b10) begin
        mem[a2] <= wdata_q[15:8];
        mem[a3] <= wdata_q[7:0];
      end
    end
  end
  // handshake FSM: latch request in IDLE, count down in ACCESS, hold result in ACK until MOV drops
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      data_out_q <= 32'd0;
      err_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (MOV) begin
          rw_q    <= R_W;
          size_q  <= size;
          se_q    <= SE;
          addr_q  <= address;
          wdata_q <= data_in;
          cnt_q   <= 4'(LATENCY - 1);
          state_q <= ACCESS;
        end
        ACCESS: if (cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
        else begin
          state_q    <= ACK;
          err_q      <= fault;
          data_out_q <= fault ? 32'd0 : rw_q ? rdata : data_out_q;
        end
        ACK: if (!MOV) begin
          state_q <= IDLE;
          err_q   <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign data_out = data_out_q;
  assign err      = err_q;
  assign MOC      = state_q == ACK;
endmodule
